// File: rtl/instr_seq_pkg.sv
// rtl/instr_seq_pkg.sv - shared state, opcode and ALU code definitions for instr_sequencer
package instr_seq_pkg;

    typedef enum logic [3:0] {
        S_IDLE, S_F0, S_F1, S_DEC, S_OA, S_OD, S_EXS, S_HLT, S_PAUSE
    } state_e;

    typedef enum logic [3:0] {
        OP_NONE, OP_LD, OP_ADD, OP_SUB, OP_AND, OP_XOR, OP_OR, OP_SHL, OP_HALT
    } op_e;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;
    localparam logic [2:0] ALU_SHL = 3'd5;

    // LD passes memory data straight through, so it carries no ALU function
    function automatic logic [2:0] alu_code(input op_e op);
        case (op)
            OP_ADD:  return ALU_ADD;
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            OP_XOR:  return ALU_XOR;
            OP_SHL:  return ALU_SHL;
            default: return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/instr_sat_counter.sv
// rtl/instr_sat_counter.sv - saturating up-counter with synchronous active-low clear
module instr_sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // advance on inc, holding at all-ones instead of wrapping
    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // count register
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - fetch/decode/execute control FSM; INSTR_SEQ_STEP_EN adds single-step PAUSE
module instr_sequencer #(
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
`ifdef INSTR_SEQ_STEP_EN
    input  logic             STEP,
`endif
    input  logic             MEM_RDY,
    input  logic             HALT,
    input  logic             LD,
    input  logic             ADD,
    input  logic             SUB,
    input  logic             AND,
    input  logic             XOR,
    input  logic             OR,
    input  logic             SHL,
    output logic             MAR_LD_PC,
    output logic             MAR_LD_MEM,
    output logic             MEM_RD,
    output logic             IIR,
    output logic             PC_INC,
    output logic             ACC_LD,
    output logic             ACC_SRC,
    output logic [2:0]       ALU_OP,
    output logic             HALTED,
    output logic [CNT_W-1:0] INSTR_CNT
);

    import instr_seq_pkg::*;

    state_e state_q, state_d;
    op_e    op_q, op_d;
    op_e    dec_op;
    logic   cnt_inc;

`ifdef INSTR_SEQ_STEP_EN
    localparam state_e RETIRE_NEXT = S_PAUSE;
    logic step_q, step_d;
    logic step_rise;
    assign step_d    = STEP;
    assign step_rise = STEP && !step_q;
`else
    localparam state_e RETIRE_NEXT = S_F0;
`endif

    // priority decode of the IR flags: HALT > LD > ADD > SUB > AND > XOR > OR > SHL
    always_comb begin
        dec_op = OP_NONE;
        if      (HALT) dec_op = OP_HALT;
        else if (LD)   dec_op = OP_LD;
        else if (ADD)  dec_op = OP_ADD;
        else if (SUB)  dec_op = OP_SUB;
        else if (AND)  dec_op = OP_AND;
        else if (XOR)  dec_op = OP_XOR;
        else if (OR)   dec_op = OP_OR;
        else if (SHL)  dec_op = OP_SHL;
    end

    // next state, opcode latch and control strobes
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        cnt_inc    = 1'b0;
        MAR_LD_PC  = 1'b0;
        MAR_LD_MEM = 1'b0;
        MEM_RD     = 1'b0;
        IIR        = 1'b0;
        PC_INC     = 1'b0;
        ACC_LD     = 1'b0;
        ACC_SRC    = 1'b0;
        ALU_OP     = 3'd0;
        HALTED     = 1'b0;
        case (state_q)
            S_IDLE: if (START) state_d = S_F0;
            S_F0: begin
                MAR_LD_PC = 1'b1;
                state_d   = S_F1;
            end
            S_F1: begin
                MEM_RD = 1'b1;
                if (MEM_RDY) begin
                    IIR     = 1'b1;
                    PC_INC  = 1'b1;
                    state_d = S_DEC;
                end
            end
            S_DEC: begin
                op_d = dec_op;
                case (dec_op)
                    OP_HALT: begin
                        cnt_inc = 1'b1;
                        state_d = S_HLT;
                    end
                    OP_SHL:  state_d = S_EXS;
                    OP_NONE: begin
                        cnt_inc = 1'b1;
                        state_d = RETIRE_NEXT;
                    end
                    default: begin
                        MAR_LD_PC = 1'b1;
                        state_d   = S_OA;
                    end
                endcase
            end
            S_OA: begin
                MEM_RD = 1'b1;
                if (MEM_RDY) begin
                    MAR_LD_MEM = 1'b1;
                    PC_INC     = 1'b1;
                    state_d    = S_OD;
                end
            end
            S_OD: begin
                MEM_RD = 1'b1;
                if (MEM_RDY) begin
                    ACC_LD  = 1'b1;
                    ACC_SRC = (op_q != OP_LD);
                    ALU_OP  = alu_code(op_q);
                    cnt_inc = 1'b1;
                    state_d = RETIRE_NEXT;
                end
            end
            S_EXS: begin
                ACC_LD  = 1'b1;
                ACC_SRC = 1'b1;
                ALU_OP  = ALU_SHL;
                cnt_inc = 1'b1;
                state_d = RETIRE_NEXT;
            end
            S_HLT: HALTED = 1'b1;
`ifdef INSTR_SEQ_STEP_EN
            S_PAUSE: if (step_rise) state_d = S_F0;
`endif
            default: state_d = S_IDLE;
        endcase
        // keep every strobe quiet while reset is asserted, even mid-instruction
        if (!RST_N) begin
            cnt_inc    = 1'b0;
            MAR_LD_PC  = 1'b0;
            MAR_LD_MEM = 1'b0;
            MEM_RD     = 1'b0;
            IIR        = 1'b0;
            PC_INC     = 1'b0;
            ACC_LD     = 1'b0;
            ACC_SRC    = 1'b0;
            ALU_OP     = 3'd0;
            HALTED     = 1'b0;
        end
    end

    // state and latched opcode registers
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            op_q    <= OP_NONE;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

`ifdef INSTR_SEQ_STEP_EN
    // previous STEP level for rising-edge detection
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            step_q <= 1'b0;
        end else begin
            step_q <= step_d;
        end
    end
`endif

    instr_sat_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk   (CLK),
        .clr_n (RST_N),
        .inc   (cnt_inc),
        .cnt   (INSTR_CNT)
    );

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - scoreboard bench for instr_sequencer with a per-instruction reference model
module tb_instr_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start;
    logic       mem_rdy;
    logic [7:0] fl;

    logic       mar_ld_pc, mar_ld_mem, mem_rd, iir, pc_inc, acc_ld, acc_src, halted;
    logic [2:0] alu_op;
    logic [7:0] cnt8;
    logic       b_mar_ld_pc, b_mar_ld_mem, b_mem_rd, b_iir, b_pc_inc, b_acc_ld, b_acc_src, b_halted;
    logic [2:0] b_alu_op;
    logic [1:0] cnt2;

    instr_sequencer #(.CNT_W(8)) dut (
        .CLK(clk), .RST_N(rst_n), .START(start), .MEM_RDY(mem_rdy),
        .HALT(fl[0]), .LD(fl[1]), .ADD(fl[2]), .SUB(fl[3]),
        .AND(fl[4]), .XOR(fl[5]), .OR(fl[6]), .SHL(fl[7]),
        .MAR_LD_PC(mar_ld_pc), .MAR_LD_MEM(mar_ld_mem), .MEM_RD(mem_rd), .IIR(iir),
        .PC_INC(pc_inc), .ACC_LD(acc_ld), .ACC_SRC(acc_src), .ALU_OP(alu_op),
        .HALTED(halted), .INSTR_CNT(cnt8)
    );

    instr_sequencer #(.CNT_W(2)) dut2 (
        .CLK(clk), .RST_N(rst_n), .START(start), .MEM_RDY(mem_rdy),
        .HALT(fl[0]), .LD(fl[1]), .ADD(fl[2]), .SUB(fl[3]),
        .AND(fl[4]), .XOR(fl[5]), .OR(fl[6]), .SHL(fl[7]),
        .MAR_LD_PC(b_mar_ld_pc), .MAR_LD_MEM(b_mar_ld_mem), .MEM_RD(b_mem_rd), .IIR(b_iir),
        .PC_INC(b_pc_inc), .ACC_LD(b_acc_ld), .ACC_SRC(b_acc_src), .ALU_OP(b_alu_op),
        .HALTED(b_halted), .INSTR_CNT(cnt2)
    );

    // op index: 0 HALT, 1 LD, 2 ADD, 3 SUB, 4 AND, 5 XOR, 6 OR, 7 SHL, 8 NOP (flag bit = index)
    localparam int OP_NOP = 8;
    int alu_tab [8] = '{0, 0, 0, 1, 2, 4, 3, 5};

    logic [10:0] exp_q [$];
    int          n_q   [$];
    string       tag_q [$];
    int          n;
    int          passed = 0;
    int          total  = 0;

    logic [10:0] m_exp, m_act, m_act2;
    int          m_n, m_e8, m_e2;
    string       m_tag;

    function automatic logic [10:0] mk(input bit mpc, input bit mmem, input bit rd, input bit ir,
                                       input bit inc, input bit ld, input bit src, input int alu,
                                       input bit h);
        return {mpc, mmem, rd, ir, inc, ld, src, 3'(alu), h};
    endfunction

    function automatic bit rb();
        return $urandom_range(0, 1) == 1;
    endfunction

    function automatic logic [7:0] rf();
        return 8'($urandom);
    endfunction

    assign m_act  = {mar_ld_pc, mar_ld_mem, mem_rd, iir, pc_inc, acc_ld, acc_src, alu_op, halted};
    assign m_act2 = {b_mar_ld_pc, b_mar_ld_mem, b_mem_rd, b_iir, b_pc_inc, b_acc_ld, b_acc_src, b_alu_op, b_halted};

    // monitor: pop one expectation per observed cycle and compare both instances
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            m_exp = exp_q.pop_front();
            m_n   = n_q.pop_front();
            m_tag = tag_q.pop_front();
            m_e8  = (m_n > 255) ? 255 : m_n;
            m_e2  = (m_n > 3) ? 3 : m_n;
            total++;
            if (m_act === m_exp) passed++;
            else $display("FAIL %s ctl act=%b exp=%b (mpc,mmem,rd,iir,inc,ld,src,alu,halt) t=%0t", m_tag, m_act, m_exp, $time);
            total++;
            if (m_act2 === m_exp) passed++;
            else $display("FAIL %s ctl_w2 act=%b exp=%b t=%0t", m_tag, m_act2, m_exp, $time);
            total++;
            if (cnt8 === 8'(m_e8)) passed++;
            else $display("FAIL %s instr_cnt act=%0d exp=%0d t=%0t", m_tag, cnt8, m_e8, $time);
            total++;
            if (cnt2 === 2'(m_e2)) passed++;
            else $display("FAIL %s instr_cnt_w2 act=%0d exp=%0d t=%0t", m_tag, cnt2, m_e2, $time);
        end
    end

    // one clock cycle: drive inputs just after the edge and record what this cycle must show
    task automatic cyc(input logic [10:0] ctl, input bit rdy, input logic [7:0] f, input bit st,
                       input string tag);
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        mem_rdy = rdy;
        fl      = f;
        start   = st;
        exp_q.push_back(ctl);
        n_q.push_back(n);
        tag_q.push_back(tag);
    endtask

    task automatic rst_cyc();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        start = rb();
        n     = 0;
    endtask

    task automatic idle(input int k, input bit go);
        for (int i = 0; i < k; i++) cyc(11'd0, rb(), rf(), 1'b0, "IDLE");
        if (go) cyc(11'd0, rb(), rf(), 1'b1, "IDLE_start");
    endtask

    // one instruction from F0 to retire; wf/wa/wd are wait cycles in fetch, address and data reads
    task automatic run_instr(input int op, input int wf, input int wa, input int wd, input logic [7:0] fdec);
        cyc(mk(1,0,0,0,0,0,0,0,0), rb(), rf(), rb(), "F0");
        for (int i = 0; i < wf; i++) cyc(mk(0,0,1,0,0,0,0,0,0), 1'b0, rf(), rb(), "F1_wait");
        cyc(mk(0,0,1,1,1,0,0,0,0), 1'b1, rf(), rb(), "F1");
        if (op == 0 || op == OP_NOP) begin
            cyc(11'd0, rb(), fdec, rb(), "DEC");
            n++;
        end else if (op == 7) begin
            cyc(11'd0, rb(), fdec, rb(), "DEC");
            cyc(mk(0,0,0,0,0,1,1,5,0), rb(), rf(), rb(), "EXS");
            n++;
        end else begin
            cyc(mk(1,0,0,0,0,0,0,0,0), rb(), fdec, rb(), "DEC");
            for (int i = 0; i < wa; i++) cyc(mk(0,0,1,0,0,0,0,0,0), 1'b0, rf(), rb(), "OA_wait");
            cyc(mk(0,1,1,0,1,0,0,0,0), 1'b1, rf(), rb(), "OA");
            for (int i = 0; i < wd; i++) cyc(mk(0,0,1,0,0,0,0,0,0), 1'b0, rf(), rb(), "OD_wait");
            cyc(mk(0,0,1,0,0,1,(op != 1),alu_tab[op],0), 1'b1, rf(), rb(), "OD");
            n++;
        end
    endtask

    function automatic logic [7:0] flags_for(input int op);
        logic [7:0] hi;
        if (op == OP_NOP) return 8'd0;
        hi = (op == 7) ? 8'd0 : (8'hFF << (op + 1));
        return (8'd1 << op) | (rf() & hi);
    endfunction

    initial begin
        int op;
        rst_n = 1'b0; start = 1'b0; mem_rdy = 1'b0; fl = 8'd0; n = 0;
        rst_cyc();
        rst_cyc();
        idle(3, 1'b1);

        run_instr(2, 0, 0, 0, 8'h04);
        run_instr(1, 0, 0, 2, 8'h02);
        run_instr(1, 1, 1, 1, 8'h0A);
        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(1, OP_NOP);
            run_instr(op, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), flags_for(op));
        end

        cyc(mk(1,0,0,0,0,0,0,0,0), rb(), rf(), rb(), "F0");
        cyc(mk(0,0,1,1,1,0,0,0,0), 1'b1, rf(), rb(), "F1");
        cyc(mk(1,0,0,0,0,0,0,0,0), rb(), 8'h04, rb(), "DEC");
        cyc(mk(0,0,1,0,0,0,0,0,0), 1'b0, rf(), rb(), "OA_wait");
        rst_cyc();
        idle(4, 1'b1);

        run_instr(7, 0, 0, 0, 8'h80);
        run_instr(OP_NOP, 0, 0, 0, 8'h00);
        run_instr(0, 0, 0, 0, 8'hFF);
        for (int i = 0; i < 6; i++) cyc(mk(0,0,0,0,0,0,0,0,1), rb(), rf(), rb(), "HLT");

        rst_cyc();
        idle(1, 1'b1);
        for (int i = 0; i < 258; i++) run_instr(OP_NOP, $urandom_range(0, 1), 0, 0, 8'h00);
        run_instr(0, 0, 0, 0, 8'h01);
        for (int i = 0; i < 3; i++) cyc(mk(0,0,0,0,0,0,0,0,1), rb(), rf(), 1'b1, "HLT_sat");

        @(posedge clk);
        @(posedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
